instruction_fetch_unit: RTL and testbench

//  Producer side of the instruction interface consumed by control_unit: holds the PC, issues

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 86 ++++++++
 tb/tb_instruction_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the fetch unit and control_unit.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {instruction, pc} entries; flush has priority over push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The issue rule upstream keeps occupancy below DEPTH whenever data lands.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full))
    else $error("fetch_fifo: write into full FIFO");

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, 1-cycle-latency imem issue, prefetch FIFO and valid/ready output to decode.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned         WORDSIZE         = 64,
  parameter int unsigned         INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
  parameter int unsigned         FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         if_pc,
  input  logic                        redirect_en,
  input  logic [WORDSIZE-1:0]         redirect_pc
);

  localparam int unsigned EW = INSTRUCTION_SIZE + WORDSIZE;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;

  logic [WORDSIZE-1:0]         pc;
  logic [WORDSIZE-1:0]         infl_tag;
  logic [WORDSIZE-1:0]         last_pc;
  logic                        infl;
  logic [EW-1:0]               head;
  logic [$clog2(FIFO_DEPTH):0] occ;
  logic                        empty;
  logic                        pop;
  logic [CW-1:0]               demand;
  logic                        unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign pop       = if_valid & if_ready;
  // Entries buffered plus the word arriving now, minus what decode takes this cycle.
  assign demand    = CW'(occ) + CW'(infl) - CW'(pop);
  assign imem_req  = rst_n & ~redirect_en & (demand < CW'(FIFO_DEPTH));
  assign imem_addr = pc;

  assign if_valid    = ~empty;
  assign instruction = empty ? INSTRUCTION_SIZE'(NOP_INSTR) : head[EW-1 -: INSTRUCTION_SIZE];
  assign if_pc       = empty ? last_pc : head[WORDSIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      infl     <= 1'b0;
      infl_tag <= RESET_PC;
      last_pc  <= RESET_PC;
    end else begin
      if (pop) last_pc <= head[WORDSIZE-1:0];
      if (redirect_en) begin
        pc   <= {redirect_pc[WORDSIZE-1:2], 2'b00};
        infl <= 1'b0;
      end else begin
        infl <= imem_req;
        if (imem_req) begin
          infl_tag <= pc;
          pc       <= pc + WORDSIZE'(4);
        end
      end
    end
  end

  // A redirect flushes the FIFO, which also drops the word landing in that cycle.
  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl),
    .wdata ({imem_rdata, infl_tag}),
    .pop   (pop),
    .flush (redirect_en),
    .rdata (head),
    .count (occ),
    .empty (empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized self-checking bench for instruction_fetch_unit against a queue-based fetch model.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned W     = 64;
  localparam int unsigned IW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] instruction;
  logic [W-1:0]  if_pc;
  logic          redirect_en;
  logic [W-1:0]  redirect_pc;

  instruction_fetch_unit #(
    .WORDSIZE(W),
    .INSTRUCTION_SIZE(IW),
    .RESET_PC(RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .instruction(instruction), .if_pc(if_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h06B38183;
    if (a == 64'h4) return 32'hB67381A3;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t      q[$];
  logic [63:0] m_pc, m_last, m_tag, exp_next;
  bit          m_infl;

  logic        s_valid, s_req;
  logic [31:0] s_instr;
  logic [63:0] s_pc, s_addr;
  logic        req_d;
  logic [63:0] addr_d;

  task automatic model_reset();
    q.delete();
    m_pc     = RST_PC;
    m_last   = RST_PC;
    m_tag    = RST_PC;
    m_infl   = 0;
    exp_next = RST_PC;
    req_d    = 0;
    addr_d   = '0;
  endtask

  // One clock cycle: apply inputs, check at negedge, advance model, respond as memory.
  task automatic step(input bit rdy, input bit redir, input logic [63:0] rpc);
    bit          e_valid, e_req, pop;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    int          need;
    entry_t      e;
    if_ready    = rdy;
    redirect_en = redir;
    redirect_pc = rpc;
    @(negedge clk);
    s_valid = if_valid;  s_instr = instruction;  s_pc = if_pc;
    s_req   = imem_req;  s_addr  = imem_addr;

    e_valid = (q.size() != 0);
    e_instr = e_valid ? q[0].instr : NOP_INSTR;
    e_pc    = e_valid ? q[0].pc : m_last;
    pop     = e_valid && rdy;
    need    = q.size() + (m_infl ? 1 : 0) - (pop ? 1 : 0);
    e_req   = !redir && (need < DEPTH);

    check("if_valid", s_valid, e_valid);
    check("instruction", s_instr, e_instr);
    check("if_pc", s_pc, e_pc);
    check("imem_req", s_req, e_req);
    check("imem_addr", s_addr, m_pc);

    if (s_valid && rdy) begin
      check("accept_order", s_pc, exp_next);
      check("accept_word", s_instr, mem_word(s_pc));
      exp_next = exp_next + 64'd4;
    end

    if (pop) begin
      m_last = q[0].pc;
      void'(q.pop_front());
    end
    if (redir) begin
      q.delete();
      m_pc     = {rpc[63:2], 2'b00};
      m_infl   = 0;
      exp_next = m_pc;
    end else begin
      if (m_infl) begin
        e.instr = mem_word(m_tag);
        e.pc    = m_tag;
        q.push_back(e);
      end
      m_infl = e_req;
      if (e_req) begin
        m_tag = m_pc;
        m_pc  = m_pc + 64'd4;
      end
    end
    req_d  = s_req;
    addr_d = s_addr;

    @(posedge clk);
    #1;
    imem_rdata = req_d ? mem_word(addr_d) : $urandom();
  endtask

  // Asserts reset between clock edges and checks outputs before any edge occurs.
  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    if_ready    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    #2;
    check({tag, "_valid"}, if_valid, 1'b0);
    check({tag, "_instr"}, instruction, NOP_INSTR);
    check({tag, "_pc"}, if_pc, RST_PC);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check({tag, "_req"}, imem_req, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    imem_rdata = '0;
    do_reset("rst");

    for (int c = 0; c < 6; c++) begin
      step(1, 0, '0);
      if (c < 2) check("t2_early_valid", s_valid, 1'b0);
      if (c == 2) begin
        check("t2_instr0", s_instr, 32'h06B38183);
        check("t2_pc0", s_pc, 64'h0);
      end
      if (c == 3) begin
        check("t2_instr1", s_instr, 32'hB67381A3);
        check("t2_pc1", s_pc, 64'h4);
      end
      if (c >= 2) check("t2_pc_seq", s_pc, 64'(4 * (c - 2)));
    end

    do_reset("rst3");
    for (int c = 0; c < 6; c++) begin
      step(0, 0, '0);
      if (c >= 2) begin
        check("t3_req_stall", s_req, 1'b0);
        check("t3_head_pc", s_pc, 64'h0);
        check("t3_head_instr", s_instr, 32'h06B38183);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step(1, 0, '0);
      check("t3_release_pc", s_pc, 64'(4 * c));
    end

    do_reset("rst4");
    for (int c = 0; c < 3; c++) step(1, 0, '0);
    step(1, 1, 64'h103);
    check("t4_no_req_redir", s_req, 1'b0);
    step(1, 0, '0);
    check("t4_req_target", s_req, 1'b1);
    check("t4_addr_target", s_addr, 64'h100);
    check("t4_gap0", s_valid, 1'b0);
    step(1, 0, '0);
    check("t4_gap1", s_valid, 1'b0);
    step(1, 0, '0);
    check("t4_valid_target", s_valid, 1'b1);
    check("t4_pc_target", s_pc, 64'h100);

    do_reset("rst5");
    for (int c = 0; c < 4; c++) step(0, 0, '0);
    step(0, 1, 64'h40);
    step(0, 0, '0);
    check("t5_flushed_valid", s_valid, 1'b0);
    check("t5_flushed_nop", s_instr, NOP_INSTR);
    check("t5_restart_addr", s_addr, 64'h40);

    for (int c = 0; c < 5; c++) step(1, 0, '0);
    do_reset("t6_mid");
    for (int c = 0; c < 3; c++) step(1, 0, '0);
    check("t6_restart_pc", s_pc, RST_PC);

    for (int c = 0; c < 400; c++) begin
      bit          rdy, redir;
      logic [63:0] rpc;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = {$urandom(), $urandom()};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF5;
        2:       rpc = 64'($urandom_range(0, 255));
        default: rpc = {32'h0, $urandom()};
      endcase
      step(rdy, redir, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
